// File: rtl/m_dm_unit.sv
// M-stage data memory: lw/lh/lhu/lb/lbu/sw/sh/sb on a word array; faults block stores.
// Reads are combinational with zero latency, stores commit at the clock edge, and there is no backpressure.
module m_dm_unit #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_pc,
  input  logic        M_DM_WE,
  input  logic [2:0]  M_DM_op,
  input  logic [31:0] M_ALU_result,
  input  logic [31:0] M_DM_WD,
  output logic [31:0] M_DM_RD,
  output logic        M_DM_exc,
  output logic [15:0] M_DM_wcnt
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    OP_W  = 3'b000,
    OP_H  = 3'b001,
    OP_HU = 3'b010,
    OP_B  = 3'b011,
    OP_BU = 3'b100
  } dm_op_e;

  logic [31:0]           mem_q [DEPTH];
  logic [15:0]           wcnt_q, wcnt_d;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-3:0] idx;
  logic [1:0]            lane;
  logic [31:0]           word;
  logic [15:0]           half_v;
  logic [7:0]            byte_v;
  logic                  exc;
  logic [31:0]           rd;
  logic [3:0]            be;
  logic [31:0]           wrep, wmask, wr_word_d;
  logic                  commit;

  always_comb begin
    offset = M_ALU_result - BASE_ADDR;
    idx    = offset[ADDR_WIDTH-1:2];
    lane   = offset[1:0];
    word   = mem_q[idx];
    half_v = lane[1] ? word[31:16] : word[15:0];
    byte_v = word[8*lane +: 8];

    // Upper offset bits are range-checked, never aliased onto the array.
    exc  = (offset >> ADDR_WIDTH) != 32'd0;
    rd   = '0;
    be   = '0;
    wrep = M_DM_WD;

    case (M_DM_op)
      OP_W: begin
        if (lane != 2'b00) exc = 1'b1;
        rd = word;
        be = 4'b1111;
      end
      OP_H, OP_HU: begin
        if (lane[0]) exc = 1'b1;
        rd   = (M_DM_op == OP_H) ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{M_DM_WD[15:0]}};
      end
      OP_B, OP_BU: begin
        rd   = (M_DM_op == OP_B) ? {{24{byte_v[7]}}, byte_v} : {24'h000000, byte_v};
        be   = 4'b0001 << lane;
        wrep = {4{M_DM_WD[7:0]}};
      end
      // Illegal and unknown ops fall here, so they can never write.
      default: exc = 1'b1;
    endcase

    if (exc) rd = '0;

    wmask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wr_word_d = (word & ~wmask) | (wrep & wmask);
    commit    = M_DM_WE & ~exc;

    wcnt_d = wcnt_q;
    if (commit) wcnt_d = wcnt_q + 16'd1;

    M_DM_RD   = rd;
    M_DM_exc  = exc;
    M_DM_wcnt = wcnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      if (commit) mem_q[idx] <= wr_word_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && commit)
      $display("%0t @%h: *%h <= %h", $time, M_pc, {M_ALU_result[31:2], 2'b00}, wr_word_d);
  end
`endif

endmodule

// File: tb/tb_m_dm_unit.sv
// Bench for m_dm_unit: directed vector table, hand-written reset/same-cycle sequences,
// random traffic against a byte-addressed reference memory, and a store-counter wrap run.
module tb_m_dm_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] M_pc = 32'h0000_1000;
  logic        M_DM_WE = 1'b0;
  logic [2:0]  M_DM_op = 3'b000;
  logic [31:0] M_ALU_result = 32'h0;
  logic [31:0] M_DM_WD = 32'h0;
  logic [31:0] M_DM_RD;
  logic        M_DM_exc;
  logic [15:0] M_DM_wcnt;

  m_dm_unit dut (
    .clk          (clk),
    .reset        (reset),
    .M_pc         (M_pc),
    .M_DM_WE      (M_DM_WE),
    .M_DM_op      (M_DM_op),
    .M_ALU_result (M_ALU_result),
    .M_DM_WD      (M_DM_WD),
    .M_DM_RD      (M_DM_RD),
    .M_DM_exc     (M_DM_exc),
    .M_DM_wcnt    (M_DM_wcnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    M_DM_WE      = we;
    M_DM_op      = op;
    M_ALU_result = a;
    M_DM_WD      = d;
    M_pc         = M_pc + 32'd4;
  endtask

  // Reference memory kept as little-endian bytes.
  logic [7:0]  mb [0:4095];
  int unsigned wcnt_m;

  function automatic int unsigned op_size(input logic [2:0] op);
    case (op)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic logic ref_fault(input logic [2:0] op, input logic [31:0] a);
    int unsigned sz;
    sz = op_size(op);
    if (sz == 0) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    int unsigned sz;
    logic [31:0] r;
    if (ref_fault(op, a)) return 32'h0;
    sz = op_size(op);
    r  = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < sz) r = r | (32'(mb[a + k]) << (8 * k));
    if ((op == 3'd1 || op == 3'd3) && sz < 4 && r[8*sz-1])
      r = r | (32'hFFFF_FFFF << (8 * sz));
    return r;
  endfunction

  task automatic ref_store(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int unsigned sz;
    if (!we || ref_fault(op, a)) return;
    sz = op_size(op);
    for (int k = 0; k < 4; k++)
      if (k < sz) mb[a + k] = d[8*k +: 8];
    wcnt_m = (wcnt_m + 1) % 65536;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        exc;
    logic [15:0] wcnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Expected RD/exc/wcnt are the values seen before the edge that may commit the row.
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0, 16'd0});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0FFC, 32'h0,          32'h0000_0000, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 3'd0, 32'h0000_0008, 32'h1234_5678, 32'h0000_0000, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 3'd3, 32'h0000_0009, 32'h0000_00AB, 32'h0000_0056, 1'b0, 16'd1});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0008, 32'h0,          32'h1234_AB78, 1'b0, 16'd2});
    tbl.push_back('{1'b0, 3'd3, 32'h0000_0009, 32'h0,          32'hFFFF_FFAB, 1'b0, 16'd2});
    tbl.push_back('{1'b0, 3'd4, 32'h0000_0009, 32'h0,          32'h0000_00AB, 1'b0, 16'd2});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_0012, 32'h0000_8001, 32'h0000_0000, 1'b0, 16'd2});
    tbl.push_back('{1'b0, 3'd1, 32'h0000_0012, 32'h0,          32'hFFFF_8001, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,          32'h0000_0000, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0010, 32'h0,          32'h8001_0000, 1'b0, 16'd3});
    tbl.push_back('{1'b1, 3'd0, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16'd3});
    tbl.push_back('{1'b1, 3'd1, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16'd3});
    tbl.push_back('{1'b1, 3'd0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16'd3});
    tbl.push_back('{1'b1, 3'd0, 32'h0001_0008, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16'd3});
    tbl.push_back('{1'b1, 3'd6, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 3'd3, 32'hFFFF_FFFF, 32'h0,          32'h0000_0000, 1'b1, 16'd3});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0008, 32'h0,          32'h1234_AB78, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0004, 32'h0,          32'h0000_0000, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0, 16'd3});
    tbl.push_back('{1'b0, 3'd0, 32'h0000_0FFC, 32'h0,          32'h0000_0000, 1'b0, 16'd3});

    // Values while reset is held low.
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    chk("reset_rd", M_DM_RD, 32'h0);
    chk("reset_wcnt", {16'h0, M_DM_wcnt}, 32'h0);
    #11 reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wd);
      #2;
      chk($sformatf("vec%0d_rd", i), M_DM_RD, tbl[i].rd);
      chk($sformatf("vec%0d_exc", i), {31'h0, M_DM_exc}, {31'h0, tbl[i].exc});
      chk($sformatf("vec%0d_wcnt", i), {16'h0, M_DM_wcnt}, {16'h0, tbl[i].wcnt});
      @(posedge clk); #1;
    end

    // Same-cycle store and load of one word: old data before the edge, new after.
    drive(1'b1, 3'd0, 32'h0000_0020, 32'hDEAD_BEEF);
    #2 chk("same_cycle_old", M_DM_RD, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'h0000_0020, 32'h0);
    #2;
    chk("same_cycle_new", M_DM_RD, 32'hDEAD_BEEF);
    chk("same_cycle_wcnt", {16'h0, M_DM_wcnt}, 32'd4);

    // Mid-cycle reset clears everything at once.
    reset = 1'b0;
    #1;
    chk("midreset_rd", M_DM_RD, 32'h0);
    chk("midreset_wcnt", {16'h0, M_DM_wcnt}, 32'h0);

    // A store whose edge lands while reset is low is dropped.
    drive(1'b1, 3'd0, 32'h0000_0024, 32'h0000_0005);
    @(posedge clk); #2;
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'h0000_0024, 32'h0);
    #1;
    chk("reset_store_dropped", M_DM_RD, 32'h0);
    chk("reset_store_wcnt", {16'h0, M_DM_wcnt}, 32'h0);
    drive(1'b0, 3'd0, 32'h0000_0008, 32'h0);
    #1 chk("reset_lost_prior", M_DM_RD, 32'h0);
    @(posedge clk); #1;

    // Random traffic against the byte-level reference.
    for (int a = 0; a < 4096; a++) mb[a] = 8'h00;
    wcnt_m = 0;
    for (int n = 0; n < 1500; n++) begin
      logic        r_we;
      logic [2:0]  r_op;
      logic [31:0] r_a, r_d;
      r_we = 1'($urandom_range(0, 1));
      r_op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      case ($urandom_range(0, 9))
        0:       r_a = $urandom;
        1:       r_a = 32'($urandom_range(4080, 4111));
        default: r_a = 32'($urandom_range(0, 63));
      endcase
      r_d = $urandom;
      drive(r_we, r_op, r_a, r_d);
      #2;
      chk("rand_rd", M_DM_RD, ref_load(r_op, r_a));
      chk("rand_exc", {31'h0, M_DM_exc}, {31'h0, ref_fault(r_op, r_a)});
      chk("rand_wcnt", {16'h0, M_DM_wcnt}, wcnt_m);
      @(posedge clk); #1;
      ref_store(r_we, r_op, r_a, r_d);
    end

    // Store counter wrap after 65536 commits.
    reset = 1'b0;
    #2 reset = 1'b1;
    drive(1'b1, 3'd0, 32'h0000_0040, 32'hA5A5_0000);
    repeat (65535) @(posedge clk);
    #2 chk("wcnt_ffff", {16'h0, M_DM_wcnt}, 32'h0000_FFFF);
    @(posedge clk); #2;
    chk("wcnt_wrap", {16'h0, M_DM_wcnt}, 32'h0);
    chk("wrap_data", M_DM_RD, 32'hA5A5_0000);
    drive(1'b0, 3'd0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
